// File: rtl/frame_buffer_arbiter_pkg.sv
// Shared frame-buffer types: default widths, owner enumeration and read-tag struct.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package frame_buffer_arbiter_pkg;

    localparam int FB_ADDR_W = 15;
    localparam int FB_DATA_W = 8;
    localparam int STARVE_W  = 4;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_DISP = 2'd1,
        OWNER_LIFE = 2'd2
    } owner_e;

    // Travels beside each RAM command so the returned data can be steered.
    typedef struct packed {
        owner_e owner;
        logic   is_read;
    } tag_t;

    localparam tag_t TAG_IDLE = '{owner: OWNER_NONE, is_read: 1'b0};

    // Keeps the starvation threshold inside what a 4-bit counter can reach.
    function automatic logic [STARVE_W-1:0] clamp_limit(input int lim);
        if (lim < 1) begin
            return STARVE_W'(1);
        end
        if (lim > 15) begin
            return STARVE_W'(15);
        end
        return STARVE_W'(lim);
    endfunction

endpackage

// File: rtl/fb_starve_counter.sv
// Counts consecutive cycles a requester is refused, saturating at limit.
// Latency: atLimit is a function of the registered count (no comb path from req/gnt).
// Backpressure: none; observes the handshake only.
module fb_starve_counter
    import frame_buffer_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                gnt,
    input  logic [STARVE_W-1:0] limit,
    output logic [STARVE_W-1:0] cnt,
    output logic                atLimit
);

    assign atLimit = (cnt >= limit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!req || gnt) begin
            cnt <= '0;
        end else if (cnt < limit) begin
            cnt <= cnt + STARVE_W'(1);
        end
    end

endmodule

// File: rtl/frame_buffer_arbiter.sv
// Arbitrates VGA fetch and GameOfLife engine onto one single-port frame-buffer RAM.
// Latency: grant is combinational; read data returns with xValid two cycles after grant.
// Backpressure: req held until gnt; display wins unless life has waited STARVE_LIMIT cycles.
module frame_buffer_arbiter
    import frame_buffer_arbiter_pkg::*;
#(
    parameter int ADDR_W       = FB_ADDR_W,
    parameter int DATA_W       = FB_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dispReq,
    input  logic [ADDR_W-1:0] dispAddr,
    output logic              dispGnt,
    output logic              dispValid,
    output logic [DATA_W-1:0] dispData,
    input  logic              lifeReq,
    input  logic              lifeWe,
    input  logic [ADDR_W-1:0] lifeAddr,
    input  logic [DATA_W-1:0] lifeWData,
    output logic              lifeGnt,
    output logic              lifeValid,
    output logic [DATA_W-1:0] lifeRData,
    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic [DATA_W-1:0] memRData,
    output logic              lifeStarved
);

    localparam logic [STARVE_W-1:0] LIMIT = clamp_limit(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_cnt;
    logic                at_limit;
    logic                force_life;
    tag_t                tag_s1;
    tag_t                tag_s2;
    logic [DATA_W-1:0]   disp_hold;
    logic [DATA_W-1:0]   life_hold;

    fb_starve_counter u_starve (
        .clk     (clk),
        .rst     (rst),
        .req     (lifeReq),
        .gnt     (lifeGnt),
        .limit   (LIMIT),
        .cnt     (starve_cnt),
        .atLimit (at_limit)
    );

    // Grants are masked by reset so nothing is accepted while the pipeline is held clear.
    assign force_life  = lifeReq & at_limit;
    assign dispGnt     = rst & dispReq & ~force_life;
    assign lifeGnt     = rst & lifeReq & (~dispReq | at_limit);
    assign lifeStarved = rst & dispReq & force_life;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memEn    <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWData <= '0;
            tag_s1   <= TAG_IDLE;
        end else begin
            memEn <= dispGnt | lifeGnt;
            memWe <= lifeGnt & lifeWe;
            if (lifeGnt) begin
                memAddr  <= lifeAddr;
                memWData <= lifeWData;
                tag_s1   <= '{owner: OWNER_LIFE, is_read: ~lifeWe};
            end else if (dispGnt) begin
                memAddr <= dispAddr;
                tag_s1  <= '{owner: OWNER_DISP, is_read: 1'b1};
            end else begin
                tag_s1 <= TAG_IDLE;
            end
        end
    end

    // Second tag stage lines up with the cycle the RAM presents read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_s2 <= TAG_IDLE;
        end else begin
            tag_s2 <= tag_s1;
        end
    end

    assign dispValid = (tag_s2.owner == OWNER_DISP) && tag_s2.is_read;
    assign lifeValid = (tag_s2.owner == OWNER_LIFE) && tag_s2.is_read;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_hold <= '0;
            life_hold <= '0;
        end else begin
            if (dispValid) begin
                disp_hold <= memRData;
            end
            if (lifeValid) begin
                life_hold <= memRData;
            end
        end
    end

    assign dispData  = dispValid ? memRData : disp_hold;
    assign lifeRData = lifeValid ? memRData : life_hold;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
module tb_frame_buffer_arbiter;

    localparam int AW = 15;
    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          dispReq;
    logic [AW-1:0] dispAddr;
    logic          dispGnt;
    logic          dispValid;
    logic [DW-1:0] dispData;
    logic          lifeReq;
    logic          lifeWe;
    logic [AW-1:0] lifeAddr;
    logic [DW-1:0] lifeWData;
    logic          lifeGnt;
    logic          lifeValid;
    logic [DW-1:0] lifeRData;
    logic          memEn;
    logic          memWe;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWData;
    logic [DW-1:0] memRData;
    logic          lifeStarved;

    logic [DW-1:0] ram     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    exp_t exp_disp[$];
    exp_t exp_life[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int disp_vcnt = 0;
    int life_vcnt = 0;

    frame_buffer_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .dispReq(dispReq), .dispAddr(dispAddr), .dispGnt(dispGnt),
        .dispValid(dispValid), .dispData(dispData),
        .lifeReq(lifeReq), .lifeWe(lifeWe), .lifeAddr(lifeAddr),
        .lifeWData(lifeWData), .lifeGnt(lifeGnt), .lifeValid(lifeValid),
        .lifeRData(lifeRData),
        .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memRData(memRData), .lifeStarved(lifeStarved)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Single-port RAM: read data appears the cycle after a read command.
    always @(posedge clk) begin
        if (memEn) begin
            if (memWe) ram[memAddr] <= memWData;
            else       memRData <= ram[memAddr];
        end
    end

    function automatic logic [DW-1:0] pat(input int a);
        return DW'(a * 7 + 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string t);
        chk({t, "_memEn"}, memEn, 0);
        chk({t, "_memWe"}, memWe, 0);
        chk({t, "_memAddr"}, memAddr, 0);
        chk({t, "_memWData"}, memWData, 0);
        chk({t, "_dispValid"}, dispValid, 0);
        chk({t, "_lifeValid"}, lifeValid, 0);
        chk({t, "_dispData"}, dispData, 0);
        chk({t, "_lifeRData"}, lifeRData, 0);
        chk({t, "_lifeStarved"}, lifeStarved, 0);
        chk({t, "_dispGnt"}, dispGnt, 0);
        chk({t, "_lifeGnt"}, lifeGnt, 0);
    endtask

    // Scoreboard: expectations pushed on grant, popped when a valid appears.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            exp_disp.delete();
            exp_life.delete();
        end else begin
            chk("gnt_onehot", dispGnt & lifeGnt, 0);
            chk("valid_onehot", dispValid & lifeValid, 0);
            if (dispValid) begin
                disp_vcnt++;
                if (exp_disp.size() == 0) begin
                    chk("disp_unexpected_valid", dispValid, 0);
                end else begin
                    e = exp_disp.pop_front();
                    chk("disp_data", dispData, e.data);
                    chk("disp_latency", cyc, e.due);
                end
            end
            if (lifeValid) begin
                life_vcnt++;
                if (exp_life.size() == 0) begin
                    chk("life_unexpected_valid", lifeValid, 0);
                end else begin
                    e = exp_life.pop_front();
                    chk("life_data", lifeRData, e.data);
                    chk("life_latency", cyc, e.due);
                end
            end
            if (dispGnt) begin
                e.data = ref_mem[dispAddr];
                e.due  = cyc + 2;
                exp_disp.push_back(e);
            end
            if (lifeGnt) begin
                if (lifeWe) begin
                    ref_mem[lifeAddr] = lifeWData;
                end else begin
                    e.data = ref_mem[lifeAddr];
                    e.due  = cyc + 2;
                    exp_life.push_back(e);
                end
            end
        end
    end

    initial begin
        int v0;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     = pat(i);
            ref_mem[i] = pat(i);
        end
        rst = 1'b0; dispReq = 1'b0; dispAddr = '0;
        lifeReq = 1'b0; lifeWe = 1'b0; lifeAddr = '0; lifeWData = '0;
        repeat (2) step();

        // Requests during reset must not be granted.
        dispReq = 1'b1; lifeReq = 1'b1; lifeWe = 1'b1;
        #1;
        check_reset_outputs("rst");
        step();

        // Display-only burst, first request in the very first cycle after release.
        rst = 1'b1; lifeReq = 1'b0; lifeWe = 1'b0; dispReq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dispAddr = AW'(i);
            #1;
            chk("A_dispGnt", dispGnt, 1);
            chk("A_lifeGnt", lifeGnt, 0);
            step();
        end
        dispReq = 1'b0;
        repeat (4) step();
        chk("A_valid_count", disp_vcnt, 4);
        chk("A_hold", dispData, pat(3));

        // Contention: four display wins, then a forced life grant, then display again.
        dispReq = 1'b1; lifeWe = 1'b0; lifeAddr = AW'(16'h300);
        v0 = life_vcnt;
        for (int i = 0; i < 6; i++) begin
            dispAddr = AW'(16'h200 + ((i == 5) ? 4 : i));
            lifeReq  = (i < 5);
            #1;
            chk("B_dispGnt", dispGnt, (i != 4));
            chk("B_lifeGnt", lifeGnt, (i == 4));
            chk("B_starved", lifeStarved, (i == 4));
            step();
        end
        dispReq = 1'b0; lifeReq = 1'b0;
        repeat (4) step();
        chk("B_life_valid_count", life_vcnt, v0 + 1);
        chk("B_lifeRData", lifeRData, pat(16'h300));

        // Life write then display read of the same word.
        v0 = life_vcnt;
        lifeReq = 1'b1; lifeWe = 1'b1; lifeAddr = AW'(16'h100); lifeWData = 8'hA5;
        #1;
        chk("C_lifeGnt", lifeGnt, 1);
        step();
        lifeReq = 1'b0; lifeWe = 1'b0; dispReq = 1'b1; dispAddr = AW'(16'h100);
        #1;
        chk("C_dispGnt", dispGnt, 1);
        step();
        dispReq = 1'b0;
        repeat (4) step();
        chk("C_dispData", dispData, 8'hA5);
        chk("C_no_lifeValid", life_vcnt, v0);

        // Interleaved display and life reads.
        dispReq = 1'b1; dispAddr = AW'(16'h10);
        #1;
        chk("D_dispGnt", dispGnt, 1);
        step();
        dispReq = 1'b0; lifeReq = 1'b1; lifeWe = 1'b0; lifeAddr = AW'(16'h20);
        #1;
        chk("D_lifeGnt", lifeGnt, 1);
        step();
        lifeReq = 1'b0;
        repeat (4) step();
        chk("D_dispData", dispData, pat(16'h10));
        chk("D_lifeRData", lifeRData, pat(16'h20));

        // Reset one cycle after a grant discards the in-flight read.
        dispReq = 1'b1; dispAddr = AW'(16'h30);
        #1;
        chk("E_dispGnt", dispGnt, 1);
        step();
        dispReq = 1'b0; rst = 1'b0;
        #1;
        v0 = disp_vcnt + life_vcnt;
        check_reset_outputs("E_rst");
        step();
        check_reset_outputs("E_rst2");
        rst = 1'b1;
        repeat (5) step();
        chk("E_no_valid", disp_vcnt + life_vcnt, v0);

        // Idle period.
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("F_memEn", memEn, 0);
            chk("F_starveCnt", dut.u_starve.cnt, 0);
            chk("F_dispGnt", dispGnt, 0);
            chk("F_lifeGnt", lifeGnt, 0);
            step();
        end

        chk("queues_drained", exp_disp.size() + exp_life.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
